// File: rtl/mul_booth_seq.sv
// mul_booth_seq: iterative radix-4 Booth multiply/accumulate, 32x32(+64) -> 64, one Booth digit per cycle.
module mul_booth_seq (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_flush,
  input  logic        i_signed_op,
  input  logic        i_acc_en,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [63:0] i_acc_in,
  output logic        o_busy,
  output logic        o_done,
  output logic [63:0] o_result
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      r_state, w_next;
  logic [4:0]  r_i;
  logic [33:0] r_a;
  logic [34:0] r_b;
  logic [67:0] r_acc, w_term, w_acc_next;
  logic [63:0] r_result;
  logic [2:0]  w_d;
  logic [33:0] w_p;
  logic        w_c, w_accept, w_last;
  always_comb begin
    w_accept   = i_start & ~i_flush & (r_state != RUN);
    w_last     = r_i == 5'd16;
    w_d        = r_b[{r_i, 1'b0} +: 3];
    w_p        = (w_d == 3'b000 || w_d == 3'b111) ? '0 :
                 (w_d == 3'b001 || w_d == 3'b010) ? r_a :
                 (w_d == 3'b011) ? {r_a[32:0], 1'b0} :
                 (w_d == 3'b100) ? {~r_a[32:0], 1'b1} : ~r_a;
    w_c        = w_d[2] & ~&w_d[1:0];
    w_term     = ({{34{w_p[33]}}, w_p} + 68'(w_c)) << {r_i, 1'b0};
    w_acc_next = r_acc + w_term;
    w_next     = (r_state == RUN) ? (i_flush ? IDLE : (w_last ? DONE : RUN)) :
                 (w_accept ? RUN : IDLE);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_i      <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a   <= {{2{i_a[31] & i_signed_op}}, i_a};
        r_b   <= {{2{i_b[31] & i_signed_op}}, i_b, 1'b0};
        r_acc <= i_acc_en ? {{4{i_acc_in[63] & i_signed_op}}, i_acc_in} : '0;
        r_i   <= '0;
      end else if (r_state == RUN) begin
        r_acc <= w_acc_next;
        r_i   <= w_last ? 5'd0 : r_i + 5'd1;
        if (w_last && !i_flush) r_result <= w_acc_next[63:0];
      end
    end
  end
  assign o_busy   = r_state == RUN;
  assign o_done   = r_state == DONE;
  assign o_result = r_result;
endmodule

// File: doc/mul_booth_seq.md
# mul_booth_seq

Iterative radix-4 Booth multiply/accumulate unit: retires one Booth digit per cycle to form a 32x32->64 product, signed or unsigned, with optional 64-bit accumulate. It consumes Booth-selected partial products (multiplicand, shifted multiplicand, or their ones' complement plus carry-in) and sums them into a running product. It sits in the execute stage behind the multiply instruction issue logic and serves MUL/MLA/UMULL/SMULL/UMLAL/SMLAL.

## Interface
Parameters: none (widths fixed at 32 in, 64 out).
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  launch request; accepted only when busy=0
- flush  in  1  pipeline cancel; aborts an operation in progress
- signed_op  in  1  1 = operands two's complement, 0 = unsigned
- acc_en  in  1  1 = add acc_in to the product
- a  in  32  multiplicand
- b  in  32  multiplier
- acc_in  in  64  accumulate addend
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, result valid
- result  out  64  (a*b + (acc_en ? acc_in : 0)) mod 2^64

## Operation
- States: IDLE, RUN, DONE. Digit counter i, 5 bits, 0..16.
- IDLE/DONE + start: latch operands; A34 = {2{a[31]&signed_op}, a}; B = {2{b[31]&signed_op}, b, 1'b0} (35 bits, implicit 0 below LSB); acc68 = acc_en ? sign/zero-extended acc_in (extension follows signed_op) : 0; i=0; go RUN.
- RUN, each cycle: digit d = B[2i+2:2i]; select 34-bit part P and carry-in c:
  - 000,111: P=0, c=0
  - 001,010: P=A34, c=0
  - 011: P={A34[32:0],0}, c=0
  - 100: P={~A34[32:0],1}, c=1
  - 101,110: P=~A34, c=1
  - acc68 += (sign-extend P to 68 bits + c) << 2i, mod 2^68. (Implementation may use a shifting accumulator; result must match.)
  - i==16: go DONE; else i++.
- DONE: result <= acc68[63:0] (registered on RUN->DONE edge, so result is valid while done=1); done=1 for exactly this cycle; return to IDLE unless start is asserted.
- result holds its value in IDLE until the next DONE; it is not cleared by start or flush.
- start while in RUN: ignored, no queuing.
- flush in RUN: go IDLE next cycle, no done pulse, result unchanged. flush in IDLE/DONE: no effect. flush and start asserted together with busy=0: flush wins, start dropped.
- Operand inputs are sampled only on the accepting edge; later changes have no effect.

## Timing
- Reset (asynchronous, reset=0): state=IDLE, i=0, busy=0, done=0, result=0, internal accumulator=0. Reset asserted mid-RUN aborts with no done pulse.
- start sampled high at edge k (busy=0): busy=1 in cycles k+1..k+17 (17 RUN cycles); done=1 and busy=0 in cycle k+18; result valid from cycle k+18.
- Fixed latency 18 cycles start->done, independent of operand values or signedness (no early termination).
- Back-to-back: start during the DONE cycle is accepted; next done follows 18 cycles later; throughput is one op per 18 cycles.
- busy is a registered state decode; done is a registered pulse; no combinational path from inputs to outputs.

## Test plan
- Unsigned max: signed_op=0, a=b=0xFFFFFFFF, acc_en=0 -> done at k+18, result=0xFFFFFFFE00000001.
- Signed corners: signed_op=1, a=b=0xFFFFFFFF -> 0x0000000000000001; a=b=0x80000000 -> 0x4000000000000000; a=0x80000000, b=0x7FFFFFFF -> 0xC000000080000000.
- Accumulate: signed_op=0, a=3, b=5, acc_en=1, acc_in=0x10 -> 0x1F; signed_op=1, a=0xFFFFFFFE (-2), b=3, acc_in=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFF9.
- Flush/reset: start a=7, b=9; flush at k+5 -> busy=0 at k+6, no done, result keeps prior value; repeat with reset low at k+9 -> busy=0, done=0, result=0 immediately.
- Back-to-back + ignored start: start op1 (2*3), pulse start at k+4 with other operands (ignored), start op2 (4*5) in op1's DONE cycle -> result=6 at k+18, result=20 at k+36, exactly two done pulses.
- Random: 10k random a/b/acc_in/signed_op/acc_en against 64-bit reference model; busy/done cycle counts checked every op.
